// File: rtl/nios2_cordic_cpu_mulx_pkg.sv
// Shared definitions for the sequential MUL/MULX unit: op encodings, FSM states, half width.
package nios2_cordic_cpu_mulx_pkg;
   localparam int DATA_W = 32;
   localparam int HALF_W = DATA_W / 2;

   localparam logic [1:0] MULX_OP_MUL    = 2'b00;
   localparam logic [1:0] MULX_OP_MULXUU = 2'b01;
   localparam logic [1:0] MULX_OP_MULXSU = 2'b10;
   localparam logic [1:0] MULX_OP_MULXSS = 2'b11;

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORR, DONE} mulx_state_t;
endpackage

// File: rtl/nios2_cordic_cpu_mulx_pp16.sv
// 16x16 unsigned partial-product multiplier with MULT_PIPE register stages.
// No enable: the owning FSM knows when a product emerges by counting cycles.
module nios2_cordic_cpu_mulx_pp16
   import nios2_cordic_cpu_mulx_pkg::*;
#(
   parameter int MULT_PIPE = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [HALF_W-1:0]   a,
   input  logic [HALF_W-1:0]   b,
   output logic [2*HALF_W-1:0] p
);
   logic [MULT_PIPE:1][2*HALF_W-1:0] stg;

   // Product enters stage 1, then ripples through the remaining stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stg <= '0;
      end else begin
         stg[1] <= {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
         for (int i = 2; i <= MULT_PIPE; i++) stg[i] <= stg[i-1];
      end
   end

   assign p = stg[MULT_PIPE];
endmodule

// File: rtl/nios2_cordic_cpu_mulx_seq.sv
// Multi-cycle 32x32 multiplier (MUL low word, MULXUU/SU/SS high word) built from four
// 16x16 unsigned partial products accumulated into a 64-bit register.
// NIOS2_CORDIC_MULX_SIGNED_EN: when defined, MULXSU/MULXSS apply the signed high-word
// correction; otherwise they behave as MULXUU (CORR state still traversed, same latency).
module nios2_cordic_cpu_mulx_seq #(
   parameter int DATA_W    = 32,
   parameter int MULT_PIPE = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              M_mulx_start,
   input  logic [1:0]        M_mulx_op,
   input  logic [DATA_W-1:0] M_mulx_src1,
   input  logic [DATA_W-1:0] M_mulx_src2,
   output logic              M_mulx_busy,
   output logic              M_mulx_done,
   output logic [DATA_W-1:0] M_mulx_result
);
   import nios2_cordic_cpu_mulx_pkg::*;

   mulx_state_t               state, nxt;
   logic [1:0]                cnt;
   logic [1:0]                dcnt;
   logic [DATA_W-1:0]         a_q, b_q;
   logic [1:0]                op_q;
   logic [2*DATA_W-1:0]       acc;
   logic [2*DATA_W-1:0]       addend;
   logic [MULT_PIPE:1]        vld_pipe;
   logic [MULT_PIPE:1][1:0]   cnt_pipe;
   logic [HALF_W-1:0]         pp_a, pp_b;
   logic [2*HALF_W-1:0]       pp;
   logic [DATA_W-1:0]         hi;
   logic                      issue;

   // cnt bit0 selects the A half, bit1 the B half: 0 aL*bL, 1 aH*bL, 2 aL*bH, 3 aH*bH.
   assign pp_a  = cnt[0] ? a_q[DATA_W-1:HALF_W] : a_q[HALF_W-1:0];
   assign pp_b  = cnt[1] ? b_q[DATA_W-1:HALF_W] : b_q[HALF_W-1:0];
   assign issue = (state == ISSUE);

   nios2_cordic_cpu_mulx_pp16 #(.MULT_PIPE(MULT_PIPE)) u_pp16 (
      .clk     (clk),
      .reset_n (reset_n),
      .a       (pp_a),
      .b       (pp_b),
      .p       (pp)
   );

   // Align the emerging product to its weight using the issue index carried down the pipe.
   always_comb begin
      addend = '0;
      case (cnt_pipe[MULT_PIPE])
         2'd0:    addend = {{DATA_W{1'b0}}, pp};
         2'd3:    addend = {pp, {DATA_W{1'b0}}};
         default: addend = {{HALF_W{1'b0}}, pp, {HALF_W{1'b0}}};
      endcase
   end

   // Signed high-word correction: subtract the other operand for each negative signed operand.
`ifdef NIOS2_CORDIC_MULX_SIGNED_EN
   logic [DATA_W-1:0] corr_a, corr_b;
   always_comb begin
      corr_a = (op_q[1] && a_q[DATA_W-1]) ? b_q : '0;
      corr_b = ((op_q == MULX_OP_MULXSS) && b_q[DATA_W-1]) ? a_q : '0;
      hi     = acc[2*DATA_W-1:DATA_W] - corr_a - corr_b;
   end
`else
   assign hi = acc[2*DATA_W-1:DATA_W];
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   // Next-state: fixed schedule regardless of op and data.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (M_mulx_start) nxt = ISSUE;
         ISSUE:   if (cnt == 2'd3) nxt = DRAIN;
         DRAIN:   if (dcnt == 2'(MULT_PIPE - 1)) nxt = CORR;
         CORR:    nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Operand capture, issue/drain counters, accumulator and result register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q           <= '0;
         b_q           <= '0;
         op_q          <= '0;
         cnt           <= '0;
         dcnt          <= '0;
         acc           <= '0;
         M_mulx_result <= '0;
      end else begin
         cnt  <= (state == ISSUE) ? cnt + 2'd1 : 2'd0;
         dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
         if (state == IDLE && M_mulx_start) begin
            a_q  <= M_mulx_src1;
            b_q  <= M_mulx_src2;
            op_q <= M_mulx_op;
            acc  <= '0;
         end else if (vld_pipe[MULT_PIPE]) begin
            acc  <= acc + addend;
         end
         if (state == CORR)
            M_mulx_result <= (op_q == MULX_OP_MUL) ? acc[DATA_W-1:0] : hi;
      end
   end

   // Valid/index shift register tracking products in flight through the pp16 pipe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         cnt_pipe <= '0;
      end else begin
         vld_pipe[1] <= issue;
         cnt_pipe[1] <= cnt;
         for (int i = 2; i <= MULT_PIPE; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            cnt_pipe[i] <= cnt_pipe[i-1];
         end
      end
   end

   assign M_mulx_busy = (state != IDLE);
   assign M_mulx_done = (state == DONE);
endmodule

// File: tb/tb_nios2_cordic_cpu_mulx_seq.sv
// Scoreboard bench for nios2_cordic_cpu_mulx_seq: expected result and done cycle are
// queued at the start edge and checked by a negedge monitor, along with busy/done timing.
module tb_nios2_cordic_cpu_mulx_seq;
   localparam int P   = 1;
   localparam int LAT = 6 + P;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] s1 = '0, s2 = '0;
   logic        busy, done;
   logic [31:0] result;

   nios2_cordic_cpu_mulx_seq #(.DATA_W(32), .MULT_PIPE(P)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .M_mulx_start  (start),
      .M_mulx_op     (op),
      .M_mulx_src1   (s1),
      .M_mulx_src2   (s2),
      .M_mulx_busy   (busy),
      .M_mulx_done   (done),
      .M_mulx_result (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   int          due_q[$];
   bit          mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_mulx(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [63:0] ea, eb, pr;
      logic [1:0]  eo;
      eo = o;
`ifndef NIOS2_CORDIC_MULX_SIGNED_EN
      if (eo[1]) eo = 2'b01;
`endif
      ea = {32'b0, a};
      eb = {32'b0, b};
      if (eo[1])        ea = {{32{a[31]}}, a};
      if (eo == 2'b11)  eb = {{32{b[31]}}, b};
      pr = ea * eb;
      return (eo == 2'b00) ? pr[31:0] : pr[63:32];
   endfunction

   // Monitor: busy/done against the scoreboard schedule, result on each done.
   always @(negedge clk) begin
      if (mon_en) begin
         logic eb, ed;
         eb = (due_q.size() > 0) && (cyc >= due_q[0] - (LAT - 1));
         ed = (due_q.size() > 0) && (cyc == due_q[0]);
         chk("busy", {31'b0, busy}, {31'b0, eb});
         chk("done", {31'b0, done}, {31'b0, ed});
         if (done && exp_q.size() > 0) begin
            chk("result", result, exp_q.pop_front());
            void'(due_q.pop_front());
         end
      end
   end

   task automatic push_exp(input logic [31:0] e);
      exp_q.push_back(e);
      due_q.push_back(cyc + 5 + P);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      chk("timeout", exp_q.size(), 0);
      exp_q.delete();
      due_q.delete();
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e);
      @(negedge clk);
      start = 1'b1; op = o; s1 = a; s2 = b;
      @(posedge clk); #1;
      push_exp(e);
      start = 1'b0; op = 2'($urandom); s1 = $urandom; s2 = $urandom;
      wait_idle();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // Directed ops
      run_op(2'b00, 32'h0001_0002, 32'h0003_0004, 32'h000A_0008);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op(2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001);
`ifdef NIOS2_CORDIC_MULX_SIGNED_EN
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      run_op(2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
      run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
`else
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op(2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002);
      run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
`endif

      // Back-to-back with start held and operands churning every cycle
      begin
         int nxt_cap = -1;
         int got = 0;
         @(negedge clk);
         start = 1'b1;
         while (got < 6) begin
            op = 2'($urandom); s1 = pick(); s2 = pick();
            @(posedge clk); #1;
            if (nxt_cap < 0 || cyc == nxt_cap) begin
               push_exp(ref_mulx(op, s1, s2));
               nxt_cap = cyc + 7 + P;
               got++;
               if (got == 6) start = 1'b0;
            end
            if (start) @(negedge clk);
         end
         wait_idle();
      end

      // Ensure a nonzero result is held before the reset test
      run_op(2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

      // Reset in cycle 3 of an op
      @(negedge clk);
      start = 1'b1; op = 2'b01; s1 = 32'h1234_5678; s2 = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      push_exp(ref_mulx(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
      start = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      reset_n = 1'b0;
      exp_q.delete();
      due_q.delete();
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      run_op(2'b01, 32'h0002_0000, 32'h0002_0000, 32'h0000_0004);

      // Random ops for each opcode against the 64-bit reference
      for (int o = 0; o < 4; o++) begin
         for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = pick(); b = pick();
            run_op(2'(o), a, b, ref_mulx(2'(o), a, b));
         end
      end

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
